// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and sizing helper for the CORDIC rotation engine.
package cordic_pkg;

  localparam logic SIGN_POS = 1'b1;
  localparam logic SIGN_NEG = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cordic_rot_engine_if.sv
// Valid/ready request and response channels of the CORDIC rotation engine.
interface cordic_rot_engine_if #(
  parameter int DATA_W   = 13,
  parameter int ITER_NUM = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic signed [DATA_W-1:0] in_y;
  logic [ITER_NUM-1:0]      in_sign;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_x;
  logic signed [DATA_W-1:0] out_y;
  logic                     busy;

  modport master (
    output in_valid, in_x, in_y, in_sign, out_ready,
    input  in_ready, out_valid, out_x, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_sign, out_ready,
    output in_ready, out_valid, out_x, out_y, busy
  );
endinterface

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation with a run-time shift amount.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int SH_W   = 4
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic [SH_W-1:0]          shift,
  input  logic                     sign,
  output logic signed [DATA_W-1:0] x_nxt,
  output logic signed [DATA_W-1:0] y_nxt
);
  logic signed [DATA_W-1:0] xs, ys;

  assign xs    = x >>> shift;
  assign ys    = y >>> shift;
  assign x_nxt = (sign == SIGN_POS) ? x + ys : x - ys;
  assign y_nxt = (sign == SIGN_POS) ? y - xs : y + xs;
endmodule

// File: rtl/cordic_rot_engine.sv
// Iterative CORDIC rotation engine: UNROLL chained micro-rotations per cycle,
// optional constant-gain compensation, valid/ready on both sides.
module cordic_rot_engine
  import cordic_pkg::*;
#(
  parameter int DATA_W   = 13,
  parameter int ITER_NUM = 8,
  parameter int UNROLL   = 2,
  parameter int SCALE_EN = 0,
  parameter int K_COEF   = 622,
  parameter int K_W      = 10
) (
  input logic              clk,
  input logic              rst_n,
  cordic_rot_engine_if.slave bus
);
  localparam int R     = ceil_div(ITER_NUM, UNROLL);
  localparam int CNT_W = $clog2(ITER_NUM + 1);
  localparam int SUM_W = $clog2(R * UNROLL + 1);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int P_W   = DATA_W + K_W + 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic [ITER_NUM-1:0]      sign_q, sign_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

  // Rotation chain: stage u applies iteration cnt_q+u, or passes through past the end.
  logic [UNROLL:0][DATA_W-1:0] cx, cy;
  assign cx[0] = x_q;
  assign cy[0] = y_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rot
    logic [SUM_W-1:0]    iter;
    logic                act;
    logic [ITER_NUM-1:0] sign_sh;
    logic [DATA_W-1:0]   rx, ry;

    assign iter    = SUM_W'(cnt_q) + SUM_W'(u);
    assign act     = iter < SUM_W'(ITER_NUM);
    assign sign_sh = sign_q >> iter;

    cordic_micro_rot #(.DATA_W(DATA_W), .SH_W(SH_W)) u_micro (
      .x     (cx[u]),
      .y     (cy[u]),
      .shift (SH_W'(iter)),
      .sign  (sign_sh[0]),
      .x_nxt (rx),
      .y_nxt (ry)
    );

    assign cx[u+1] = act ? rx : cx[u];
    assign cy[u+1] = act ? ry : cy[u];
  end

  logic [SUM_W-1:0] cnt_sum;
  logic             last_rot;
  assign cnt_sum  = SUM_W'(cnt_q) + SUM_W'(UNROLL);
  assign last_rot = cnt_sum >= SUM_W'(ITER_NUM);

  // Gain compensation: round half up, then keep DATA_W bits (wraps like the rest).
  logic signed [DATA_W-1:0] x_sc, y_sc;
  if (SCALE_EN != 0) begin : g_scale
    localparam logic signed [K_W:0]   KC  = (K_W+1)'(K_COEF);
    localparam logic signed [P_W-1:0] RND = P_W'(2 ** (K_W - 1));
    logic signed [P_W-1:0] px, py;
    assign px   = P_W'(x_q) * P_W'(KC) + RND;
    assign py   = P_W'(y_q) * P_W'(KC) + RND;
    assign x_sc = DATA_W'(px >>> K_W);
    assign y_sc = DATA_W'(py >>> K_W);
  end else begin : g_noscale
    assign x_sc = x_q;
    assign y_sc = y_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        x_d     = bus.in_x;
        y_d     = bus.in_y;
        sign_d  = bus.in_sign;
        cnt_d   = '0;
        state_d = ROT;
      end
      ROT: begin
        x_d   = cx[UNROLL];
        y_d   = cy[UNROLL];
        cnt_d = last_rot ? '0 : CNT_W'(cnt_sum);
        if (last_rot) begin
          if (SCALE_EN != 0) begin
            state_d = SCALE;
          end else begin
            out_x_d     = cx[UNROLL];
            out_y_d     = cy[UNROLL];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      SCALE: begin
        out_x_d     = x_sc;
        out_y_d     = y_sc;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sign_q      <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == ROT) || (state_q == SCALE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
endmodule

// File: tb/tb_cordic_rot_engine.sv
// Runs every UNROLL in 1..8 unscaled plus one scaled engine in lock-step against an
// arithmetic CORDIC model.
module tb_cordic_rot_engine;
  import cordic_pkg::*;

  localparam int DW = 13;
  localparam int IN = 8;
  localparam int NI = 9;  // 0..7: UNROLL=g+1 unscaled; 8: UNROLL=2 scaled

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 in_valid, out_ready;
  logic signed [DW-1:0] in_x, in_y;
  logic [IN-1:0]        in_sign;

  logic                 ov [NI];
  logic                 ir [NI];
  logic                 bz [NI];
  logic signed [DW-1:0] ox [NI];
  logic signed [DW-1:0] oy [NI];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int U  = (g == NI - 1) ? 2 : g + 1;
    localparam int SC = (g == NI - 1) ? 1 : 0;
    cordic_rot_engine_if #(.DATA_W(DW), .ITER_NUM(IN)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_x      = in_x;
    assign bus.in_y      = in_y;
    assign bus.in_sign   = in_sign;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign bz[g] = bus.busy;
    assign ox[g] = bus.out_x;
    assign oy[g] = bus.out_y;
    cordic_rot_engine #(
      .DATA_W(DW), .ITER_NUM(IN), .UNROLL(U), .SCALE_EN(SC), .K_COEF(622), .K_W(10)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  function automatic int wrap(input int v);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return int'($signed(t));
  endfunction

  // Rotation straight from the iteration equations, on plain integers.
  function automatic void model(input int x0, input int y0, input logic [IN-1:0] s,
                                input bit sc, output int xr, output int yr);
    int x, y, t;
    x = x0;
    y = y0;
    for (int k = 0; k < IN; k++) begin
      if (s[k]) begin t = wrap(x + (y >>> k)); y = wrap(y - (x >>> k)); end
      else      begin t = wrap(x - (y >>> k)); y = wrap(y + (x >>> k)); end
      x = t;
    end
    if (sc) begin
      x = wrap((x * 622 + 512) >>> 10);
      y = wrap((y * 622 + 512) >>> 10);
    end
    xr = x;
    yr = y;
  endfunction

  function automatic int lat_exp(input int g);
    int u;
    int sc;
    u  = (g == NI - 1) ? 2 : g + 1;
    sc = (g == NI - 1) ? 1 : 0;
    return (IN + u - 1) / u + sc + 1;
  endfunction

  function automatic bit all_ready();
    bit r = 1'b1;
    for (int g = 0; g < NI; g++) r &= ir[g];
    return r;
  endfunction

  function automatic bit all_valid();
    bit r = 1'b1;
    for (int g = 0; g < NI; g++) r &= ov[g];
    return r;
  endfunction

  task automatic wait_ready();
    int e = 0;
    while (!all_ready() && e < 50) begin @(posedge clk); #1; e++; end
    total++;
    if (!all_ready()) begin bad++; $display("FAIL idle_wait: engines not ready after %0d cycles", e); end
  endtask

  // Accept on one edge (edge 1), scramble inputs, wait for all outputs, check, release.
  task automatic run_vector(input int x0, input int y0, input logic [IN-1:0] s, input bit chk_lat);
    int lat [NI];
    int e, ex, ey;
    wait_ready();
    in_x = DW'(x0); in_y = DW'(y0); in_sign = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = DW'($urandom); in_y = DW'($urandom); in_sign = IN'($urandom);
    e = 1;
    for (int g = 0; g < NI; g++) lat[g] = ov[g] ? e : 0;
    while (!all_valid() && e < 30) begin
      @(posedge clk); #1; e++;
      for (int g = 0; g < NI; g++) if (ov[g] && lat[g] == 0) lat[g] = e;
    end
    for (int g = 0; g < NI; g++) begin
      model(x0, y0, s, g == NI - 1, ex, ey);
      total++;
      if (ox[g] !== DW'(ex) || oy[g] !== DW'(ey)) begin
        bad++;
        $display("FAIL result[%0d] in=(%0d,%0d) sign=%h got=(%0d,%0d) exp=(%0d,%0d)",
                 g, x0, y0, s, ox[g], oy[g], ex, ey);
      end
      if (chk_lat) begin
        total++;
        if (lat[g] != lat_exp(g)) begin
          bad++;
          $display("FAIL latency[%0d] got=%0d exp=%0d", g, lat[g], lat_exp(g));
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (ov[g] !== 1'b0 || ir[g] !== 1'b1) begin
        bad++;
        $display("FAIL release[%0d] out_valid=%b in_ready=%b exp 0/1", g, ov[g], ir[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_sign = '0;
    #12;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (ov[g] !== 1'b0 || bz[g] !== 1'b0 || ir[g] !== 1'b1 || ox[g] !== '0 || oy[g] !== '0) begin
        bad++;
        $display("FAIL reset[%0d] ov=%b busy=%b ir=%b out=(%0d,%0d) exp 0/0/1/(0,0)",
                 g, ov[g], bz[g], ir[g], ox[g], oy[g]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_vector(1024, 0, 8'h00, 1'b1);
    for (int g = 0; g < NI; g++) begin
      int ex = (g == NI - 1) ? -168 : -276;
      int ey = (g == NI - 1) ? 1010 : 1662;
      total++;
      if (ox[g] !== DW'(ex) || oy[g] !== DW'(ey)) begin
        bad++;
        $display("FAIL directed[%0d] got=(%0d,%0d) exp=(%0d,%0d)", g, ox[g], oy[g], ex, ey);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_vector(int'($urandom_range(2048)) - 1024, int'($urandom_range(2048)) - 1024,
                 IN'($urandom), 1'b1);
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] hx [NI];
    logic signed [DW-1:0] hy [NI];
    int e = 0;
    int ex, ey;
    wait_ready();
    in_x = 13'sd700; in_y = -13'sd300; in_sign = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!all_valid() && e < 30) begin @(posedge clk); #1; e++; end
    for (int g = 0; g < NI; g++) begin hx[g] = ox[g]; hy[g] = oy[g]; end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        total++;
        if (ov[g] !== 1'b1 || ir[g] !== 1'b0 || ox[g] !== hx[g] || oy[g] !== hy[g]) begin
          bad++;
          $display("FAIL hold[%0d] cyc=%0d ov=%b ir=%b out=(%0d,%0d) exp 1/0/(%0d,%0d)",
                   g, c, ov[g], ir[g], ox[g], oy[g], hx[g], hy[g]);
        end
      end
    end
    // Release and offer a new vector in the same cycle: it must wait for IDLE.
    out_ready = 1'b1; in_valid = 1'b1;
    in_x = -13'sd512; in_y = 13'sd900; in_sign = 8'h3C;
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (ov[g] !== 1'b0 || ir[g] !== 1'b1 || bz[g] !== 1'b0) begin
        bad++;
        $display("FAIL no_accept_in_done[%0d] ov=%b ir=%b busy=%b exp 0/1/0", g, ov[g], ir[g], bz[g]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (ir[g] !== 1'b0) begin
        bad++;
        $display("FAIL second_accept[%0d] in_ready=%b exp 0", g, ir[g]);
      end
    end
    e = 0;
    while (!all_valid() && e < 30) begin @(posedge clk); #1; e++; end
    for (int g = 0; g < NI; g++) begin
      model(-512, 900, 8'h3C, g == NI - 1, ex, ey);
      total++;
      if (ox[g] !== DW'(ex) || oy[g] !== DW'(ey)) begin
        bad++;
        $display("FAIL second_result[%0d] got=(%0d,%0d) exp=(%0d,%0d)", g, ox[g], oy[g], ex, ey);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_ready();
    in_x = 13'sd333; in_y = 13'sd444; in_sign = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bz[0] !== 1'b1) begin bad++; $display("FAIL busy_before_reset got=%b exp 1", bz[0]); end
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (ov[g] !== 1'b0 || bz[g] !== 1'b0 || ox[g] !== '0 || oy[g] !== '0) begin
        bad++;
        $display("FAIL async_reset[%0d] ov=%b busy=%b out=(%0d,%0d) exp 0/0/(0,0)",
                 g, ov[g], bz[g], ox[g], oy[g]);
      end
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vector(-1000, 250, 8'h96, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
